// File: rtl/vedic_mul_pkg.sv
// Shared FSM state and partial-product index encodings for the sequential Vedic multiplier.
package vedic_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] idx_t;

    localparam idx_t IDX_LL = 2'd0;
    localparam idx_t IDX_LH = 2'd1;
    localparam idx_t IDX_HL = 2'd2;
    localparam idx_t IDX_HH = 2'd3;

endpackage

// File: rtl/vedic_mul_half.sv
// Combinational HALF x HALF unsigned multiplier, Urdhva-Tiryagbhyam (vertically-crosswise) form.
module vedic_mul_half
    import vedic_mul_pkg::*;
#(
    parameter int HALF = 4
) (
    input  logic [HALF-1:0]   i_a,
    input  logic [HALF-1:0]   i_b,
    output logic [2*HALF-1:0] o_p
);

    logic [2*HALF-1:0] w_col;
    logic [2*HALF-1:0] w_sum;

    // Each column k collects every crosswise bit product a[i]&b[j] with i+j==k.
    always_comb begin
        w_sum = '0;
        w_col = '0;
        for (int k = 0; k < 2*HALF-1; k++) begin
            w_col = '0;
            for (int i = 0; i < HALF; i++) begin
                for (int j = 0; j < HALF; j++) begin
                    if (i + j == k) begin
                        w_col = w_col + {{(2*HALF-1){1'b0}}, i_a[i] & i_b[j]};
                    end
                end
            end
            w_sum = w_sum + (w_col << k);
        end
        o_p = w_sum;
    end

endmodule

// File: rtl/vedic_mul_seq.sv
// Sequential multiplier: four HALF x HALF partial products through one Vedic sub-multiplier.
// Optional signed operation is enabled by defining VEDIC_MUL_SIGNED_EN.
module vedic_mul_seq
    import vedic_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] s,
    output logic               busy
`ifdef VEDIC_MUL_SIGNED_EN
    ,
    input  logic               signed_mode
`endif
);

    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return v[WIDTH-1] ? n : v;
    endfunction

    function automatic logic [PW-1:0] f_neg(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] n;
        n = -v;
        return n;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    idx_t             r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sign;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_s;

    logic             w_sm;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic             w_sign_in;
    logic [HALF-1:0]  w_x;
    logic [HALF-1:0]  w_y;
    logic [WIDTH-1:0] w_pp;
    logic [PW-1:0]    w_pp_ext;
    logic [PW-1:0]    w_pp_sh;
    logic [PW-1:0]    w_acc_nxt;

`ifdef VEDIC_MUL_SIGNED_EN
    assign w_sm = signed_mode;
`else
    assign w_sm = 1'b0;
`endif

    // Signed operands are reduced to magnitudes; the sign is reapplied on the final edge.
    assign w_a_in    = w_sm ? f_mag(a) : a;
    assign w_b_in    = w_sm ? f_mag(b) : b;
    assign w_sign_in = w_sm & (a[WIDTH-1] ^ b[WIDTH-1]);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_MUL;
            end
            ST_MUL: begin
                if (r_idx == IDX_HH) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) w_state_nxt = in_valid ? ST_MUL : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign s         = r_s;

    always_comb begin
        w_x = r_a[HALF-1:0];
        w_y = r_b[HALF-1:0];
        case (r_idx)
            IDX_LL: begin w_x = r_a[HALF-1:0];     w_y = r_b[HALF-1:0];     end
            IDX_LH: begin w_x = r_a[HALF-1:0];     w_y = r_b[WIDTH-1:HALF]; end
            IDX_HL: begin w_x = r_a[WIDTH-1:HALF]; w_y = r_b[HALF-1:0];     end
            default: begin w_x = r_a[WIDTH-1:HALF]; w_y = r_b[WIDTH-1:HALF]; end
        endcase
    end

    vedic_mul_half #(
        .HALF(HALF)
    ) u_half (
        .i_a(w_x),
        .i_b(w_y),
        .o_p(w_pp)
    );

    assign w_pp_ext = {{(PW-WIDTH){1'b0}}, w_pp};

    always_comb begin
        w_pp_sh = w_pp_ext;
        case (r_idx)
            IDX_LL:  w_pp_sh = w_pp_ext;
            IDX_LH:  w_pp_sh = w_pp_ext << HALF;
            IDX_HL:  w_pp_sh = w_pp_ext << HALF;
            default: w_pp_sh = w_pp_ext << WIDTH;
        endcase
    end

    assign w_acc_nxt = r_acc + w_pp_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= IDX_LL;
            r_acc   <= '0;
            r_s     <= '0;
            r_sign  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a    <= w_a_in;
                r_b    <= w_b_in;
                r_sign <= w_sign_in;
                r_acc  <= '0;
                r_idx  <= IDX_LL;
            end else if (r_state == ST_MUL) begin
                r_acc <= w_acc_nxt;
                r_idx <= r_idx + 2'd1;
                if (r_idx == IDX_HH) r_s <= r_sign ? f_neg(w_acc_nxt) : w_acc_nxt;
            end
        end
    end

endmodule

// File: doc/vedic_mul_seq.md
VEDIC_MUL_SEQ -- requirements
Module: vedic_mul_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width; even, >= 4.
REQ-002 Parameter HALF, default WIDTH/2, sub-multiplier width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands a/b valid.
REQ-006 in_ready  output  1  block can accept operands this cycle.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 out_valid  output  1  product s valid.
REQ-010 out_ready  input  1  consumer accepts s this cycle.
REQ-011 s  output  2*WIDTH  product.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DONE, with a 2-bit partial-product index idx in MUL.
REQ-014 The block SHALL accept operands on an edge where in_valid && in_ready, latch a/b, clear the 2*WIDTH accumulator, and enter MUL with idx=0.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in DONE only while out_ready=1, 0 in MUL.
REQ-016 MUL SHALL compute one HALF x HALF partial product per cycle through a single sub-multiplier, in the order idx0 aL*bL (shift 0), idx1 aL*bH (shift HALF), idx2 aH*bL (shift HALF), idx3 aH*bH (shift WIDTH), adding each into the accumulator.
REQ-017 Accumulation SHALL be 2*WIDTH unsigned modulo 2^(2*WIDTH); the final result SHALL equal a*b exactly.
REQ-018 After the idx3 edge, the FSM SHALL enter DONE with out_valid=1; latency is 4 cycles from the accept edge to out_valid high.
REQ-019 s SHALL remain stable while out_valid=1 and out_ready=0; in_valid is ignored during this stall.
REQ-020 In DONE with out_ready=1 and in_valid=0, the FSM SHALL return to IDLE and deassert out_valid.
REQ-021 In DONE with out_ready=1 and in_valid=1, the block SHALL complete the output transfer and accept new operands on the same edge, entering MUL idx=0 (one result every 5 cycles).
REQ-022 s SHALL retain the last product in IDLE until the next product overwrites it.

Reset
REQ-023 On rst=1 at an edge, the FSM SHALL go to IDLE, with idx=0, accumulator=0, s=0, out_valid=0 and busy=0; in_ready SHALL be 1 in the following cycle.
REQ-024 rst SHALL take priority over every handshake; an operation in MUL or DONE is discarded without output.

Configuration
REQ-025 Macro VEDIC_MUL_SIGNED_EN: when defined, the block SHALL add input port signed_mode (1 bit), sampled at the accept edge.
REQ-026 With the macro defined and signed_mode=1, operands SHALL be two's-complement: latch magnitudes, record sign = sign(a) XOR sign(b), and negate the product on the idx3 edge; the latency stays 4 cycles.
REQ-027 With the macro defined and signed_mode=0, or with the macro undefined (port absent), the block SHALL operate unsigned only.

Structure
REQ-028 A shared package vedic_mul_pkg SHALL hold the FSM state enum and the idx encodings (IDX_LL, IDX_LH, IDX_HL, IDX_HH).
REQ-029 A combinational sub-module vedic_mul_half (HALF x HALF -> 2*HALF, vertically-crosswise) SHALL be instantiated exactly once.

Verification
REQ-030 WIDTH=8: a=15, b=15, out_ready=1 -> out_valid 4 cycles after accept, s=225, then IDLE.
REQ-031 WIDTH=8: a=158, b=157, out_ready held 0 for 3 cycles -> s=24806 held stable, in_ready=0 until out_ready=1.
REQ-032 WIDTH=8: back-to-back 29*28 then 9*9 with in_valid high in DONE -> s=812 then s=81, second accept on the same edge as the first output transfer.
REQ-033 WIDTH=8: rst asserted at idx=2 of 255*255 -> next cycle out_valid=0, s=0, in_ready=1; then 255*255 -> s=65025.
REQ-034 VEDIC_MUL_SIGNED_EN, signed_mode=1: -128*-128 -> s=16384; -3*5 -> s=0xFFF1; signed_mode=0 with 0xFD*5 -> s=1265.
REQ-035 WIDTH=16: 65535*65535 -> s=0xFFFE0001 after 4 cycles.
